// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem handshake and
// presents one {instruction, pc+4} slot to the IF/ID register, with NOP bubbles when empty.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] instruction_out,
    output logic [31:0] pcplus4_out,
    output logic [31:0] pc_out
);

    // state   | meaning
    // S_REQ   | request for pc may be issued this cycle
    // S_WAIT  | request accepted, response for pc pending
    // S_DRAIN | response pending for a flushed request; discard it
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;
    logic        req;

    assign pc_plus4 = pc_q + 32'd4;

    // Requests only when the slot will be empty by the time the response returns.
    assign req = !reset && (state_q == S_REQ) && !redirect && (!valid_q || !stall);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC_AL;
            instr_q <= NOP_INSTR;
            pcp4_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;

        if (valid_q && !stall) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (req && imem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                    instr_d = imem_rdata;
                    pcp4_d  = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Redirect overrides everything above, including a same-cycle response and stall.
        if (redirect) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            instr_d = instr_q;
            pcp4_d  = pcp4_q;
            valid_d = 1'b0;
            state_d = ((state_q == S_REQ) || imem_rvalid) ? S_REQ : S_DRAIN;
        end
    end

    assign imem_req        = req;
    assign imem_addr       = pc_q;
    assign fetch_valid     = valid_q;
    assign instruction_out = valid_q ? instr_q : NOP_INSTR;
    assign pcplus4_out     = pcp4_q;
    assign pc_out          = pc_q;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Owns the PC and drives the instruction-memory request/response handshake.
- Produces the {PCPlus4, Instruction} pair that the IF/ID pipeline register captures whenever that register's Stall input is low.
- Honours the same Stall signal and a branch/jump redirect from the decode/execute side.
- Inserts a NOP bubble whenever no fetched instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding driven on instruction_out when no valid instruction is held.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  same net as the IF/ID Stall; 1 = the held instruction is not consumed this edge.
- redirect  in  1  taken branch/jump; flushes fetch.
- redirect_pc  in  32  new PC; valid when redirect=1.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address; equals the current PC.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid; one-cycle pulse per accepted request.
- imem_rdata  in  32  instruction word.
- fetch_valid  out  1  instruction_out / pcplus4_out hold a real instruction.
- instruction_out  out  32  to IF/ID Instruction_in.
- pcplus4_out  out  32  to IF/ID PCPlus4_in.
- pc_out  out  32  current PC (debug/trace).

Behaviour:
- Reset (asynchronous):
  - pc = RESET_PC, state = REQ.
  - Output slot empty: fetch_valid = 0, instruction_out = NOP_INSTR, pcplus4_out = 0.
  - imem_req is forced to 0 while reset is high.
  - Reset asserted mid-transaction abandons any outstanding response; a late imem_rvalid after reset is ignored because state is REQ.
- Output slot: one entry {instr, pcp4, valid}. It is consumed at any rising edge where valid=1 and stall=0. When valid=0, instruction_out = NOP_INSTR and pcplus4_out holds its last value.
- At most one memory request outstanding. Address is always word-aligned; imem_addr[1:0] = 2'b00.
- imem_req = (state==REQ) && !redirect && (!fetch_valid || !stall). This guarantees a returning response always lands in an empty slot.
- State REQ:
  - imem_req && imem_ready -> WAIT.
  - Otherwise stay in REQ; imem_addr stays stable while imem_req is held.
- State WAIT, on imem_rvalid with no redirect:
  - Slot <= {imem_rdata, pc+4}, valid = 1.
  - pc <= pc+4, wrapping modulo 2^32.
  - Next state REQ.
- State DRAIN: waits for imem_rvalid, discards the data, then -> REQ.
- Redirect has highest priority and acts at the edge where redirect=1:
  - pc <= redirect_pc and slot valid <= 0, i.e. the bubble is visible the next cycle. This applies even if stall=1 in the same cycle.
  - From REQ -> REQ. No handshake is possible this cycle, since imem_req is gated.
  - From WAIT without rvalid -> DRAIN.
  - From WAIT with rvalid in the same cycle -> REQ; the response is discarded.
  - From DRAIN without rvalid -> stay in DRAIN with the new pc.
  - From DRAIN with rvalid in the same cycle -> REQ.
- Throughput: at most 1 instruction per 2 cycles (REQ, WAIT). Memory latency is arbitrary, ≥1 cycle after acceptance.
- Stall while the slot is valid: slot contents and pc are held, and no new request is issued.
- Stall while the slot is empty: has no effect on the fetch in flight.

Test Plan:
- Reset release, memory has ready=1 and latency 1, rdata = 32'h2001_0005 at 0x0 and 32'h2002_0007 at 0x4, stall=0 -> imem_addr sequence 0x0, 0x4, 0x8. fetch_valid pulses with (instr 0x2001_0005, pcp4 0x4), then (0x2002_0007, 0x8). NOP_INSTR is shown between fetches.
- Slot valid with instr 0x8C43_0000, stall held for 3 cycles -> outputs stable; imem_req=0 throughout; pc unchanged; fetch resumes the cycle after stall drops.
- Redirect to 0x40 while in WAIT, rvalid arriving 2 cycles later with data 0xDEAD_BEEF -> 0xDEAD_BEEF is never presented; next imem_addr = 0x40; fetch_valid=0 until the 0x40 response arrives.
- Redirect with stall=1 and slot valid -> slot flushed (instruction_out = NOP_INSTR); pc = redirect_pc next cycle.
- imem_ready held low for 4 cycles -> imem_req stays 1; imem_addr is stable at the current pc; no state advance.
- pc = 0xFFFF_FFFC fetch completes -> pcplus4_out = 0x0000_0000; next imem_addr = 0x0. Reset asserted during WAIT -> all outputs take reset values immediately; a stray rvalid afterwards is ignored.
